sc_fifo: RTL and testbench

SC_FIFO -- requirements
Module: sc_fifo

---
 rtl/sc_fifo.sv | 104 ++++++++++
 tb/tb_sc_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sc_fifo.sv
// rtl/sc_fifo.sv - single-clock first-word-fall-through FIFO with level and almost-full/almost-empty flags
// Define SC_FIFO_ERR_EN to add sticky overflow/underflow flags (err_ovf, err_udf).
module sc_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int ADDR_BITS    = 4,
  parameter int AFULL_LEVEL  = 2**ADDR_BITS - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_we,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_full,
  output logic                 wr_afull,
  input  logic                 rd_oe,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_empty,
  output logic                 rd_aempty,
  output logic [ADDR_BITS:0]   level
`ifdef SC_FIFO_ERR_EN
  ,
  output logic                 err_ovf,
  output logic                 err_udf
`endif
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0]   DEPTH_L  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   AFULL_L  = (ADDR_BITS+1)'(AFULL_LEVEL);
  localparam logic [ADDR_BITS:0]   AEMPTY_L = (ADDR_BITS+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_BITS:0]   LVL_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = (ADDR_BITS)'(1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   level_q, level_d;
  logic                 wr_acc, rd_acc;

  // Status comes only from the registered level, so accept decisions see pre-edge state.
  assign wr_full   = (level_q == DEPTH_L);
  assign rd_empty  = (level_q == '0);
  assign wr_afull  = (level_q >= AFULL_L);
  assign rd_aempty = (level_q <= AEMPTY_L);
  assign level     = level_q;
  assign rd_data   = mem_q[rd_ptr_q];

  assign wr_acc = wr_we & ~wr_full;
  assign rd_acc = rd_oe & ~rd_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef SC_FIFO_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (wr_we & wr_full);
    err_udf_d = err_udf_q | (rd_oe & rd_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_sc_fifo.sv
// tb/tb_sc_fifo.sv - self-checking bench for sc_fifo against a queue-based reference model
module tb_sc_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_we;
  logic [7:0] wr_data;
  logic       wr_full, wr_afull;
  logic       rd_oe;
  logic [7:0] rd_data;
  logic       rd_empty, rd_aempty;
  logic [2:0] level;
`ifdef SC_FIFO_ERR_EN
  logic       err_ovf, err_udf;
`endif

  sc_fifo #(
    .DATA_BITS(8), .ADDR_BITS(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_we(wr_we), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull),
    .rd_oe(rd_oe), .rd_data(rd_data), .rd_empty(rd_empty), .rd_aempty(rd_aempty),
    .level(level)
`ifdef SC_FIFO_ERR_EN
    , .err_ovf(err_ovf), .err_udf(err_udf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue, sticky error bits.
  logic [7:0] model_q[$];
  bit         m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, ":level"},     32'(level),     32'(n));
    check({tag, ":full"},      32'(wr_full),   32'(n == 4));
    check({tag, ":empty"},     32'(rd_empty),  32'(n == 0));
    check({tag, ":afull"},     32'(wr_afull),  32'(n >= 3));
    check({tag, ":aempty"},    32'(rd_aempty), 32'(n <= 1));
    if (n > 0) check({tag, ":head"}, 32'(rd_data), 32'(model_q[0]));
`ifdef SC_FIFO_ERR_EN
    check({tag, ":ovf"}, 32'(err_ovf), 32'(m_ovf));
    check({tag, ":udf"}, 32'(err_udf), 32'(m_udf));
`endif
  endtask

  // One clock: drive at negedge, apply the rules to the model using pre-edge contents, check after the edge.
  task automatic step(input string tag, input bit r, input bit we, input logic [7:0] d, input bit oe);
    bit full_pre, empty_pre;
    logic [7:0] head_pre;
    @(negedge clk);
    rst = r; wr_we = we; wr_data = d; rd_oe = oe;
    full_pre  = (model_q.size() == 4);
    empty_pre = (model_q.size() == 0);
    #1;
    if (!r && oe && !empty_pre) begin
      head_pre = model_q[0];
      check({tag, ":pop"}, 32'(rd_data), 32'(head_pre));
    end
    @(posedge clk);
    if (r) begin
      model_q.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      if (we && full_pre)  m_ovf = 1;
      if (oe && empty_pre) m_udf = 1;
      if (oe && !empty_pre) void'(model_q.pop_front());
      if (we && !full_pre)  model_q.push_back(d);
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; wr_we = 1'b0; wr_data = '0; rd_oe = 1'b0;
    m_ovf = 0; m_udf = 0;

    step("reset", 1, 0, 8'h00, 0);
    step("reset2", 1, 1, 8'h99, 1);

    // Fill to full, then drain in order.
    step("w11", 0, 1, 8'h11, 0);
    step("w22", 0, 1, 8'h22, 0);
    step("w33", 0, 1, 8'h33, 0);
    step("w44", 0, 1, 8'h44, 0);
    check("full_after_4", 32'(wr_full), 32'(1));
    step("r1", 0, 0, 8'h00, 1);
    step("r2", 0, 0, 8'h00, 1);
    step("r3", 0, 0, 8'h00, 1);
    step("r4", 0, 0, 8'h00, 1);
    check("empty_after_4", 32'(rd_empty), 32'(1));

    // Write while full with concurrent read: write dropped.
    for (int i = 0; i < 4; i++) step("fill", 0, 1, 8'(8'h60 + i), 0);
    step("ovf_wr", 0, 1, 8'h55, 1);
    check("ovf_level", 32'(level), 32'(3));
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 8'h00, 1);

    // Read while empty with concurrent write: read ignored, word visible next cycle.
    step("udf_rd", 0, 1, 8'hA5, 1);
    check("udf_level", 32'(level), 32'(1));
    check("udf_data", 32'(rd_data), 32'(8'hA5));
    step("drainA5", 0, 0, 8'h00, 1);

    // Steady-state streaming at level 2 through pointer wraps.
    step("pre1", 0, 1, 8'hC0, 0);
    step("pre2", 0, 1, 8'hC1, 0);
    for (int i = 0; i < 20; i++) step("stream", 0, 1, 8'(8'hD0 + i), 1);
    check("stream_level", 32'(level), 32'(2));

    // Reset mid-operation with a concurrent write.
    step("lvl3", 0, 1, 8'hE0, 0);
    step("rst_mid", 1, 1, 8'hEE, 0);
    check("rst_mid_level", 32'(level), 32'(0));
    step("w77", 0, 1, 8'h77, 0);
    check("w77_head", 32'(rd_data), 32'(8'h77));
    step("r77", 0, 0, 8'h00, 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
           8'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
